// File: rtl/jt49_bussched_pkg.sv
// jt49_bussched_pkg: shared types and constants for the PSG register-bus
// scheduler (FSM state encoding, grant IDs, queued player-write entry).
package jt49_bussched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WRITE,
      ST_READ,
      ST_RECOVER
   } state_t;

   // Grant owner; also remembered as last_grant for round-robin.
   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_PLR = 1'b1
   } gnt_t;

   // Envelope-shape register: every write must be a distinct strobe edge.
   localparam logic [3:0] REG_ENV_SHAPE = 4'hD;

   // Read strobe length is fixed by the PSG's registered dout.
   localparam int READ_CYC = 2;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } plr_wr_t;

endpackage

// File: rtl/jt49_bussched_if.sv
// jt49_bussched_if: bus bundle between requesters, scheduler and PSG.
//   cpu_*  : CPU request/ack handshake with read data return
//   plr_*  : player write stream (valid/ready), flush and FIFO level
//   psg_*  : PSG register port (addr/din/cs_n/wr_n out, dout in)
// slave = scheduler view, master = requester/PSG side view.
interface jt49_bussched_if #(parameter int FIFO_AW = 2);
   logic             cpu_req;
   logic             cpu_we;
   logic [3:0]       cpu_addr;
   logic [7:0]       cpu_din;
   logic             cpu_ack;
   logic [7:0]       cpu_dout;
   logic             plr_valid;
   logic [3:0]       plr_addr;
   logic [7:0]       plr_data;
   logic             plr_ready;
   logic             plr_flush;
   logic [FIFO_AW:0] plr_level;
   logic [3:0]       psg_addr;
   logic [7:0]       psg_din;
   logic             psg_cs_n;
   logic             psg_wr_n;
   logic [7:0]       psg_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      output cpu_ack, cpu_dout,
      input  plr_valid, plr_addr, plr_data, plr_flush,
      output plr_ready, plr_level,
      output psg_addr, psg_din, psg_cs_n, psg_wr_n,
      input  psg_dout
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      input  cpu_ack, cpu_dout,
      output plr_valid, plr_addr, plr_data, plr_flush,
      input  plr_ready, plr_level,
      input  psg_addr, psg_din, psg_cs_n, psg_wr_n,
      output psg_dout
   );
endinterface

// File: rtl/jt49_bussched_fifo.sv
// jt49_bussched_fifo: synchronous FIFO of queued player writes.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_push      : push request (ignored while full)
//   i_pop       : pop request (ignored while empty)
//   i_flush     : empty the FIFO; wins over a same-cycle push
//   i_wdata     : entry to push
//   o_rdata     : head entry (valid while !o_empty)
//   o_level     : occupancy, 0..2**AW
//   o_full/o_empty : status
module jt49_bussched_fifo
   import jt49_bussched_pkg::*;
#(
   parameter int AW = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_push,
   input  logic    i_pop,
   input  logic    i_flush,
   input  plr_wr_t i_wdata,
   output plr_wr_t o_rdata,
   output logic [AW:0] o_level,
   output logic    o_full,
   output logic    o_empty
);
   localparam int DEPTH = 1 << AW;

   plr_wr_t       r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
   end
endmodule

// File: rtl/jt49_bussched.sv
// jt49_bussched: shares the jt49 register port between a CPU requester
// (read/write) and a buffered player write stream, round-robin arbitrated.
// Each access is setup (1) / strobe (WR_CYC write, 2 read) / recover (1),
// so back-to-back envelope-shape writes always see a fresh wr_n edge.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : cpu_*, plr_*, psg_* bundle (slave modport)
//   o_busy     : scheduler not idle
module jt49_bussched
   import jt49_bussched_pkg::*;
#(
   parameter int WR_CYC  = 2,
   parameter int FIFO_AW = 2
) (
   input  logic clk,
   input  logic rst_n,
   jt49_bussched_if.slave bus,
   output logic o_busy
);
   localparam int CNT_W = $clog2(WR_CYC + 1);

   state_t           r_state, w_state_nxt;
   gnt_t             r_last;   // owner of the current/most recent grant
   logic [CNT_W-1:0] r_cnt;
   logic             r_we;
   logic [3:0]       r_addr;
   logic [7:0]       r_din;
   logic             r_cs_n, r_wr_n, r_ack;
   logic [7:0]       r_dout;

   plr_wr_t          w_head;
   logic             w_full, w_empty;
   logic             w_plr_cand, w_pick_cpu, w_grant;
   logic [FIFO_AW:0] w_level;

   // A flushing FIFO is not a candidate: its entries are being discarded.
   assign w_plr_cand = ~w_empty & ~bus.plr_flush;
   assign w_pick_cpu = bus.cpu_req & (~w_plr_cand | (r_last == GNT_PLR));

   jt49_bussched_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (bus.plr_valid),
      .i_pop   (w_grant & ~w_pick_cpu),
      .i_flush (bus.plr_flush),
      .i_wdata ({bus.plr_addr, bus.plr_data}),
      .o_rdata (w_head),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         ST_IDLE: if (bus.cpu_req || w_plr_cand) begin
            w_grant     = 1'b1;
            w_state_nxt = ST_SETUP;
         end
         ST_SETUP:   w_state_nxt = r_we ? ST_WRITE : ST_READ;
         ST_WRITE:   if (r_cnt == CNT_W'(WR_CYC - 1))   w_state_nxt = ST_RECOVER;
         ST_READ:    if (r_cnt == CNT_W'(READ_CYC - 1)) w_state_nxt = ST_RECOVER;
         ST_RECOVER: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= GNT_PLR;   // CPU wins the first tie
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         r_cs_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_ack   <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == r_state && (r_state == ST_WRITE || r_state == ST_READ))
            r_cnt <= r_cnt + CNT_W'(1);
         else
            r_cnt <= '0;
         if (w_grant) begin
            r_last <= w_pick_cpu ? GNT_CPU : GNT_PLR;
            r_we   <= w_pick_cpu ? bus.cpu_we   : 1'b1;
            r_addr <= w_pick_cpu ? bus.cpu_addr : w_head.addr;
            r_din  <= w_pick_cpu ? bus.cpu_din  : w_head.data;
         end
         // Strobes and ack are registered from the next state so they line
         // up exactly with the state they belong to, glitch-free.
         r_cs_n <= ~(w_state_nxt == ST_WRITE || w_state_nxt == ST_READ);
         r_wr_n <= ~(w_state_nxt == ST_WRITE);
         r_ack  <= (w_state_nxt == ST_RECOVER) && (r_last == GNT_CPU);
         // Reads are only ever CPU grants, so no owner check is needed here.
         if (r_state == ST_READ && w_state_nxt == ST_RECOVER)
            r_dout <= bus.psg_dout;
      end
   end

   assign bus.psg_addr  = r_addr;
   assign bus.psg_din   = r_din;
   assign bus.psg_cs_n  = r_cs_n;
   assign bus.psg_wr_n  = r_wr_n;
   assign bus.cpu_ack   = r_ack;
   assign bus.cpu_dout  = r_dout;
   assign bus.plr_ready = ~w_full;
   assign bus.plr_level = w_level;
   assign o_busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_jt49_bussched.sv
// tb_jt49_bussched: randomized self-checking bench. A PSG device model holds
// register contents; a bus monitor rebuilds each access from the strobes and
// matches it against a queue of expected accesses built from the arbitration
// rules (CPU-only order, CPU then player backlog, strict alternation).
module tb_jt49_bussched;
   import jt49_bussched_pkg::*;

   localparam int WR_CYC  = 2;
   localparam int FIFO_AW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   jt49_bussched_if #(.FIFO_AW(FIFO_AW)) bus();

   jt49_bussched #(.WR_CYC(WR_CYC), .FIFO_AW(FIFO_AW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .o_busy (busy)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] din;
   } acc_t;

   acc_t       exp_q[$];
   logic [7:0] exp_reg [16];
   logic [7:0] psg_regs [16];
   logic       seeded = 1'b0;

   function automatic logic [7:0] init_val(input logic [3:0] a);
      return (a == 4'h7) ? 8'hB8 : {a, ~a};
   endfunction

   // PSG device: registers written on a low wr_n strobe, dout registered.
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 16; i++) psg_regs[i] <= init_val(4'(i));
         seeded <= 1'b1;
      end else if (!bus.psg_cs_n && !bus.psg_wr_n) begin
         psg_regs[bus.psg_addr] <= bus.psg_din;
      end
      bus.psg_dout <= psg_regs[bus.psg_addr];
   end

   // Bus monitor
   int         skip_req = 0;
   int         skip_done = 0;
   logic       mon_bad = 1'b0;
   initial begin
      logic       prev_cs, have;
      int         len, wrlow, gap;
      logic [3:0] a;
      logic [7:0] d;
      acc_t       e;
      prev_cs = 1'b1; have = 1'b0; len = 0; wrlow = 0; gap = 0; a = '0; d = '0;
      forever begin
         @(negedge clk);
         if (!bus.psg_cs_n) begin
            if (prev_cs) begin
               if (have) chk("strobe_gap_ge2", gap >= 2, 1);
               len = 0; wrlow = 0; a = bus.psg_addr; d = bus.psg_din;
            end else if (bus.psg_addr !== a || bus.psg_din !== d) begin
               mon_bad = 1'b1;
            end
            len++;
            if (!bus.psg_wr_n) wrlow++;
         end else begin
            if (!bus.psg_wr_n) mon_bad = 1'b1;
            if (!prev_cs) begin
               if (skip_done != skip_req) skip_done++;
               else if (exp_q.size() == 0) chk("unexpected_access", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("acc_addr", a, e.addr);
                  chk("acc_is_write", wrlow != 0, e.we);
                  chk("acc_len", len, e.we ? WR_CYC : 2);
                  if (e.we) begin
                     chk("acc_din", d, e.din);
                     chk("acc_wr_low", wrlow, WR_CYC);
                  end
               end
               gap = 0;
               have = 1'b1;
            end
            gap++;
         end
         prev_cs = bus.psg_cs_n;
      end
   end

   task automatic cpu_xact(input logic we, input logic [3:0] a, input logic [7:0] d,
                           input logic chk_lat);
      int n;
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.cpu_ack && n < 100);
      bus.cpu_req = 1'b0;
      if (n >= 100) chk("cpu_ack_timeout", 0, 1);
      else begin
         if (chk_lat) chk("ack_latency", n, we ? WR_CYC + 2 : 4);
         if (!we) chk("cpu_rd_data", bus.cpu_dout, exp_reg[a]);
      end
      if (we) exp_reg[a] = d;
      @(negedge clk);
      chk("ack_one_cycle", bus.cpu_ack, 0);
   endtask

   task automatic plr_push(input logic [3:0] a, input logic [7:0] d);
      int n;
      n = 0;
      bus.plr_valid = 1'b1; bus.plr_addr = a; bus.plr_data = d;
      while (!bus.plr_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("push_timeout", 0, 1);
      @(negedge clk);
      bus.plr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || bus.plr_level != 0) && n < 300) begin @(negedge clk); n++; end
      chk("idle_reached", n < 300, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [3:0] ra;
      logic [7:0] rd;
      logic       rw;
      logic [3:0] pa [5];
      logic [7:0] pd [5];
      logic [3:0] ca [4];
      logic [7:0] cd [4];
      int         acks;

      for (int i = 0; i < 16; i++) exp_reg[i] = init_val(4'(i));
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
      bus.plr_valid = 1'b0; bus.plr_addr = '0; bus.plr_data = '0; bus.plr_flush = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_cs_n", bus.psg_cs_n, 1);
      chk("rst_wr_n", bus.psg_wr_n, 1);
      chk("rst_addr", bus.psg_addr, 0);
      chk("rst_din", bus.psg_din, 0);
      chk("rst_ack", bus.cpu_ack, 0);
      chk("rst_dout", bus.cpu_dout, 0);
      chk("rst_level", bus.plr_level, 0);
      chk("rst_ready", bus.plr_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single CPU write and read
      exp_q.push_back('{1'b1, 4'h8, 8'h0F});
      cpu_xact(1'b1, 4'h8, 8'h0F, 1'b1);
      chk("wr_addr_held", bus.psg_addr, 4'h8);
      chk("wr_din_held", bus.psg_din, 8'h0F);
      exp_q.push_back('{1'b0, 4'h7, 8'h00});
      cpu_xact(1'b0, 4'h7, 8'h00, 1'b1);
      chk("rd_b8", bus.cpu_dout, 8'hB8);
      wait_idle();

      // random CPU-only traffic; reads return what the bus wrote earlier
      for (int i = 0; i < 12; i++) begin
         rw = 1'($urandom_range(0, 1)); ra = 4'($urandom); rd = 8'($urandom);
         exp_q.push_back('{rw, ra, rd});
         cpu_xact(rw, ra, rd, 1'b1);
      end
      wait_idle();

      // CPU write keeps the bus busy while the player fills the FIFO
      ra = 4'($urandom); rd = 8'($urandom);
      for (int i = 0; i < 5; i++) begin pa[i] = 4'($urandom); pd[i] = 8'($urandom); end
      exp_q.push_back('{1'b1, ra, rd});
      for (int i = 0; i < 5; i++) exp_q.push_back('{1'b1, pa[i], pd[i]});
      fork
         cpu_xact(1'b1, ra, rd, 1'b0);
         begin
            for (int i = 0; i < 4; i++) plr_push(pa[i], pd[i]);
            bus.plr_valid = 1'b1; bus.plr_addr = pa[4]; bus.plr_data = pd[4];
            chk("full_ready_low", bus.plr_ready, 0);
            chk("full_level", bus.plr_level, 4);
            plr_push(pa[4], pd[4]);
         end
      join
      wait_idle();
      chk("drained_level", bus.plr_level, 0);

      // two envelope-shape writes back to back
      pd[0] = 8'($urandom); pd[1] = 8'($urandom);
      exp_q.push_back('{1'b1, REG_ENV_SHAPE, pd[0]});
      exp_q.push_back('{1'b1, REG_ENV_SHAPE, pd[1]});
      plr_push(REG_ENV_SHAPE, pd[0]);
      plr_push(REG_ENV_SHAPE, pd[1]);
      wait_idle();

      // flush: one in flight, three queued, push alongside the flush
      for (int i = 0; i < 5; i++) begin pa[i] = 4'($urandom); pd[i] = 8'($urandom); end
      exp_q.push_back('{1'b1, pa[0], pd[0]});
      for (int i = 0; i < 4; i++) plr_push(pa[i], pd[i]);
      chk("pre_flush_level", bus.plr_level, 3);
      bus.plr_flush = 1'b1;
      bus.plr_valid = 1'b1; bus.plr_addr = pa[4]; bus.plr_data = pd[4];
      @(negedge clk);
      bus.plr_flush = 1'b0; bus.plr_valid = 1'b0;
      chk("flush_level", bus.plr_level, 0);
      chk("flush_ready", bus.plr_ready, 1);
      wait_idle();

      // fresh reset, then continuous contention: CPU, player, CPU, player...
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ca[i] = 4'($urandom); cd[i] = 8'($urandom);
         pa[i] = 4'($urandom); pd[i] = 8'($urandom);
         exp_q.push_back('{1'b1, ca[i], cd[i]});
         exp_q.push_back('{1'b1, pa[i], pd[i]});
      end
      fork
         begin
            int n;
            for (int i = 0; i < 4; i++) begin
               bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = ca[i]; bus.cpu_din = cd[i];
               n = 0;
               do begin @(negedge clk); n++; end while (!bus.cpu_ack && n < 200);
               if (n >= 200) chk("alt_ack_timeout", 0, 1);
            end
            bus.cpu_req = 1'b0;
         end
         begin
            for (int i = 0; i < 4; i++) plr_push(pa[i], pd[i]);
         end
      join
      wait_idle();

      // reset during a write with two player entries queued
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'($urandom); bus.cpu_din = 8'($urandom);
      bus.plr_valid = 1'b1; bus.plr_addr = 4'($urandom); bus.plr_data = 8'($urandom);
      @(negedge clk);
      bus.plr_addr = 4'($urandom); bus.plr_data = 8'($urandom);
      @(negedge clk);
      chk("in_write_cs_low", bus.psg_cs_n, 0);
      chk("pre_rst_level", bus.plr_level, 2);
      bus.plr_valid = 1'b0; bus.cpu_req = 1'b0;
      skip_req++;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", bus.psg_cs_n, 1);
      chk("abort_wr_n", bus.psg_wr_n, 1);
      chk("abort_ack", bus.cpu_ack, 0);
      chk("abort_level", bus.plr_level, 0);
      chk("abort_busy", busy, 0);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.cpu_ack) acks++;
      end
      chk("abort_no_ack", acks, 0);

      wait_idle();
      chk("all_accesses_seen", exp_q.size(), 0);
      chk("strobe_qual_stable", mon_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
